spi_slave_rx: RTL and testbench

//  Receiving end of the parity-protected SPI link: decodes frames sent by the team's SPI master
//   (SS low, DATA_W data bits LSB first, then 1 parity bit) and presents each word as a one-cycle strobe.

---
 rtl/spi_slave_rx.sv | 153 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// Receiver for the parity-protected SPI link: synchronizes SS/SCLK/SD, shifts in
// DATA_W data bits LSB first plus an even-parity bit, and acknowledges good frames on SACK.
module spi_slave_rx #(
    parameter int DATA_W      = 64,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              SS,
    input  logic              SCLK,
    input  logic              SD,
    output logic              SACK,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              VALID,
    output logic              PARITY_ERR,
    output logic              FRAME_ERR
);
    localparam int CW = $clog2(DATA_W + 3);
    localparam int IW = $clog2(DATA_W);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_PAR  = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W + 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_W + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(BIT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK, WAIT_SS} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, sd_sync;
    logic [SYNC_STAGES:0]   settle_pipe;
    logic                   ss_d, sclk_d;
    logic                   ss_s, sclk_s, sd_s;
    logic                   ss_rise, sclk_rise, settled;
    logic                   armed;

    logic [DATA_W-1:0]      shreg;
    logic [CW-1:0]          cnt;
    logic [TW-1:0]          timer;
    logic                   par, rx_par;
    logic                   start, abort;

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign ss_rise   = ss_s & ~ss_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign settled   = settle_pipe[SYNC_STAGES];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ss_sync     <= '1;
            sclk_sync   <= '0;
            sd_sync     <= '0;
            ss_d        <= 1'b1;
            sclk_d      <= 1'b0;
            settle_pipe <= '0;
            armed       <= 1'b0;
        end else begin
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sd_sync     <= {sd_sync[SYNC_STAGES-2:0], SD};
            ss_d        <= ss_s;
            sclk_d      <= sclk_s;
            settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
            // A frame may only start once SS has been seen high with real samples,
            // so a frame already in flight at reset release is never decoded.
            armed       <= armed | (settled & ss_s);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (settled && !ss_s) begin
                    state_n = armed ? RECV : WAIT_SS;
                    start   = armed;
                end
            end
            RECV: begin
                if (ss_rise) begin
                    state_n = CHECK;
                end else if (!sclk_rise && timer == TMO_LAST) begin
                    state_n = WAIT_SS;
                    abort   = 1'b1;
                end
            end
            CHECK:   state_n = IDLE;
            WAIT_SS: if (ss_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg      <= '0;
            cnt        <= '0;
            timer      <= '0;
            par        <= 1'b0;
            rx_par     <= 1'b0;
            SACK       <= 1'b0;
            DATA_OUT   <= '0;
            VALID      <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            VALID      <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= abort;
            if (start) begin
                cnt    <= '0;
                timer  <= '0;
                par    <= 1'b0;
                rx_par <= 1'b0;
                SACK   <= 1'b0;
            end
            if (state == RECV) begin
                if (sclk_rise) begin
                    timer <= '0;
                    if (cnt < CNT_PAR) begin
                        shreg[cnt[IW-1:0]] <= sd_s;
                        par                <= par ^ sd_s;
                    end else if (cnt == CNT_PAR) begin
                        rx_par <= sd_s;
                    end
                    if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
                end else begin
                    timer <= timer + TW'(1);
                end
            end
            if (state == CHECK) begin
                if (cnt != CNT_FULL) begin
                    FRAME_ERR <= 1'b1;
                end else if (par != rx_par) begin
                    PARITY_ERR <= 1'b1;
                end else begin
                    DATA_OUT <= shreg;
                    VALID    <= 1'b1;
                    SACK     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames at the pins and checks pulses,
// data and SACK against hand-computed values.
module tb_spi_slave_rx;
    localparam int DATA_W      = 64;
    localparam int BIT_TIMEOUT = 255;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              SS = 1'b1;
    logic              SCLK = 1'b0;
    logic              SD = 1'b0;
    logic              SACK;
    logic [DATA_W-1:0] DATA_OUT;
    logic              VALID, PARITY_ERR, FRAME_ERR;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
    int cyc = 0, ferr_cyc = 0, sclk_cyc = 0;
    int v0, p0, f0;
    logic              in_frame = 1'b0;
    logic              sack_in_frame = 1'b0;
    logic [DATA_W-1:0] last_data = '0, prev_data = '0;

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .BIT_TIMEOUT(BIT_TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SS(SS), .SCLK(SCLK), .SD(SD),
        .SACK(SACK), .DATA_OUT(DATA_OUT), .VALID(VALID),
        .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (VALID) begin
            valid_cnt++;
            prev_data = last_data;
            last_data = DATA_OUT;
        end
        if (PARITY_ERR) perr_cnt++;
        if (FRAME_ERR) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (in_frame && SACK) sack_in_frame = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clock_bit(input logic b);
        SD = b;
        tick(3);
        SCLK = 1'b1;
        tick(3);
        SCLK = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic p, input int nbits);
        tick(1);
        SS = 1'b0;
        tick(4);
        in_frame = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i < DATA_W)       clock_bit(d[i]);
            else if (i == DATA_W) clock_bit(p);
            else                  clock_bit(1'b0);
        end
        tick(3);
        in_frame = 1'b0;
        SS = 1'b1;
    endtask

    task automatic snap();
        v0 = valid_cnt;
        p0 = perr_cnt;
        f0 = ferr_cnt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with SS low and SCLK toggling
        SS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            SCLK = ~SCLK;
            tick(2);
        end
        @(negedge CLK);
        chk("rst_sack", 64'(SACK), 64'd0);
        chk("rst_data", DATA_OUT, 64'd0);
        chk("rst_pulses", {61'd0, VALID, PARITY_ERR, FRAME_ERR}, 64'd0);
        SCLK = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        // Release mid-frame: the tail of this frame must be dropped
        tick(2);
        for (int i = 0; i < DATA_W + 1; i++) clock_bit(1'b0);
        tick(3);
        SS = 1'b1;
        tick(20);
        chk("post_rst_valid", 64'(valid_cnt), 64'd0);
        chk("post_rst_errs", 64'(perr_cnt + ferr_cnt), 64'd0);

        // Good frame
        snap();
        send(64'h0123456789ABCDEF, 1'b0, 65);
        tick(20);
        chk("good_valid", 64'(valid_cnt - v0), 64'd1);
        chk("good_data", DATA_OUT, 64'h0123456789ABCDEF);
        chk("good_sack", 64'(SACK), 64'd1);
        chk("good_errs", 64'(perr_cnt - p0 + ferr_cnt - f0), 64'd0);

        // Parity error then resend
        snap();
        send(64'h1, 1'b0, 65);
        tick(20);
        chk("perr_pulse", 64'(perr_cnt - p0), 64'd1);
        chk("perr_sack", 64'(SACK), 64'd0);
        chk("perr_data_hold", DATA_OUT, 64'h0123456789ABCDEF);
        chk("perr_no_valid", 64'(valid_cnt - v0), 64'd0);
        snap();
        send(64'h1, 1'b1, 65);
        tick(20);
        chk("resend_valid", 64'(valid_cnt - v0), 64'd1);
        chk("resend_data", DATA_OUT, 64'h1);
        chk("resend_sack", 64'(SACK), 64'd1);

        // Length errors: short and long
        snap();
        send(64'h0123456789ABCDEF, 1'b0, 40);
        tick(20);
        chk("short_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("short_sack", 64'(SACK), 64'd0);
        snap();
        send(64'h0123456789ABCDEF, 1'b0, 66);
        tick(20);
        chk("long_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("len_no_valid", 64'(valid_cnt - v0), 64'd0);
        chk("len_data_hold", DATA_OUT, 64'h1);

        // Bit timeout: 10 bits then SCLK idle with SS low
        snap();
        tick(1);
        SS = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            SD = 1'b1;
            tick(3);
            SCLK = 1'b1;
            sclk_cyc = cyc;
            tick(3);
            SCLK = 1'b0;
        end
        tick(300);
        chk("tmo_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("tmo_window", 64'((ferr_cyc - sclk_cyc >= BIT_TIMEOUT) &&
                              (ferr_cyc - sclk_cyc <= BIT_TIMEOUT + 6)), 64'd1);
        SS = 1'b1;
        tick(10);
        chk("tmo_no_extra", 64'(ferr_cnt - f0 + valid_cnt - v0), 64'd1);
        snap();
        send(64'hDEADBEEF00C0FFEE, 1'b0, 65);
        tick(20);
        chk("tmo_recover_valid", 64'(valid_cnt - v0), 64'd1);
        chk("tmo_recover_data", DATA_OUT, 64'hDEADBEEF00C0FFEE);

        // Back-to-back frames, 4 CLK SS-high gap
        snap();
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
        tick(3);
        send(64'h8000_0000_0000_0000, 1'b1, 65);
        tick(20);
        chk("b2b_valid", 64'(valid_cnt - v0), 64'd2);
        chk("b2b_first", prev_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b2b_second", last_data, 64'h8000_0000_0000_0000);
        chk("b2b_errs", 64'(perr_cnt - p0 + ferr_cnt - f0), 64'd0);

        chk("sack_never_in_frame", 64'(sack_in_frame), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
